// File: rtl/corescore_stream_pkg.sv
// Shared types and helpers for the corescore stream arbiter and its round-robin picker.
package corescore_stream_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Index width that stays at least one bit wide when there is only one source.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/corescore_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module corescore_rr_pick
  import corescore_stream_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IW      = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  // Scan from the farthest offset down so the offset closest to ptr wins last.
  // With a single source ptr is always 0 and this collapses to idx = 0.
  always_comb begin
    idx = '0;
    any = 1'b0;
    sum = '0;
    j   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_SRC)) sum = sum - (IW+1)'(NUM_SRC);
      j = sum[IW-1:0];
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream byte sink among NUM_SRC
// requesters, with one registered output stage and a wrapping delivered-packet counter.
module corescore_stream_arbiter
  import corescore_stream_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] i_tdata,
  input  logic [NUM_SRC-1:0]        i_tlast,
  input  logic [NUM_SRC-1:0]        i_tvalid,
  output logic [NUM_SRC-1:0]        o_tready,
  output logic [DATA_W-1:0]         o_tdata,
  output logic                      o_tlast,
  output logic                      o_tvalid,
  input  logic                      i_tready,
  output logic [NUM_SRC-1:0]        o_grant,
  output logic [CNT_W-1:0]          o_pkt_cnt
);

  localparam int IW = idx_w(NUM_SRC);

  state_e             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      own;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [IW-1:0]      ptr_nxt;
  logic [DATA_W-1:0]  own_data;
  logic               own_last;
  logic               own_valid;
  logic               load_en;
  logic               accept;

  corescore_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_pick (
    .req (i_tvalid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    own_data  = '0;
    own_last  = 1'b0;
    own_valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (own == IW'(k)) begin
        own_data  = i_tdata[k*DATA_W +: DATA_W];
        own_last  = i_tlast[k];
        own_valid = i_tvalid[k];
      end
    end
  end

  // Output stage can take a beat whenever it is empty or draining this cycle.
  assign load_en  = !o_tvalid || i_tready;
  assign o_tready = (state == ST_BUSY && load_en) ? o_grant : '0;
  assign accept   = (state == ST_BUSY) && load_en && own_valid;
  assign ptr_nxt  = (own == IW'(NUM_SRC - 1)) ? '0 : own + IW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      own      <= '0;
      o_grant  <= '0;
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        o_tdata  <= own_data;
        o_tlast  <= own_last;
        o_tvalid <= 1'b1;
      end else if (i_tready) begin
        o_tvalid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            own     <= pick_idx;
            o_grant <= NUM_SRC'(1) << pick_idx;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Finisher goes to the back of the queue for the next round.
          if (accept && own_last) begin
            rr_ptr  <= ptr_nxt;
            o_grant <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                           o_pkt_cnt <= '0;
    else if (o_tvalid && i_tready && o_tlast) o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
  end

endmodule
